// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg
//   Shared definitions for the multi-cycle MIPS control FSM:
//   - state encodings (also presented on the debug port state_o)
//   - opcode and funct constants
//   - ALU control codes
//   - select-field encodings for reg_dst, mem_to_reg, alu_src_b and pc_src
//   No ports; imported by mips_mc_alu_decoder and mips_mc_controller.
package mips_mc_pkg;

  typedef enum logic [4:0] {
    S_FETCH   = 5'd0,
    S_DECODE  = 5'd1,
    S_MEM_ADR = 5'd2,
    S_MEM_RD  = 5'd3,
    S_MEM_WB  = 5'd4,
    S_MEM_WR  = 5'd5,
    S_EXEC_R  = 5'd6,
    S_ALU_WB  = 5'd7,
    S_BRANCH  = 5'd8,
    S_ADDI_EX = 5'd9,
    S_ADDI_WB = 5'd10,
    S_JUMP    = 5'd11,
    S_JAL     = 5'd12,
    S_JR      = 5'd13,
    S_HALT    = 5'd14
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU control codes (zero-extended to ALU_CTRL_W at the ports)
  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  // reg_dst
  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  // mem_to_reg
  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_DATA   = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  // alu_src_b
  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // pc_src
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REG    = 2'd3;

  // True for the opcodes that take the conditional-branch path.
  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/mips_mc_alu_decoder.sv
// mips_mc_alu_decoder
//   Combinational R-type funct -> ALU control decode.
//   Ports:
//     i_funct        in  6           instruction funct field
//     o_alu_control  out ALU_CTRL_W  ALU operation code
//     o_invalid      out 1           funct is not a supported ALU operation
//   An unsupported funct still drives ADD so the datapath sees a defined,
//   harmless operation while the FSM routes the instruction to its
//   illegal-op handling.
module mips_mc_alu_decoder
  import mips_mc_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [5:0]            i_funct,
  output logic [ALU_CTRL_W-1:0] o_alu_control,
  output logic                  o_invalid
);

  logic [2:0] w_code;

  always_comb begin
    w_code    = ALU_ADD;
    o_invalid = 1'b0;
    case (i_funct)
      FN_ADD:  w_code = ALU_ADD;
      FN_SUB:  w_code = ALU_SUB;
      FN_AND:  w_code = ALU_AND;
      FN_OR:   w_code = ALU_OR;
      FN_SLT:  w_code = ALU_SLT;
      default: o_invalid = 1'b1;
    endcase
  end

  assign o_alu_control = ALU_CTRL_W'(w_code);

endmodule

// File: rtl/mips_mc_controller.sv
// mips_mc_controller
//   Multi-cycle MIPS control FSM with a memory-ready handshake.
//   Supports lw, sw, R-type (add/sub/and/or/slt), beq, bne, addi, j, jal, jr
//   and detects illegal opcodes / functs.
//
//   Parameters:
//     ALU_CTRL_W     width of alu_control
//     STATE_W        width of state_o
//     STRICT_DECODE  1: illegal instruction enters HALT; 0: treated as NOP
//
//   Ports:
//     clk, reset (async, active low)
//     op, funct          instruction fields from IR
//     zero               ALU zero flag
//     mem_ready          memory access completes this cycle
//     pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
//     reg_write, alu_src_a, alu_src_b, alu_control, pc_src
//                        datapath control set
//     state_o            current state (debug)
//     illegal_op         high while in HALT
//
//   Optional feature, macro MC_PERF_CNT_EN:
//     adds cycle_cnt[31:0] (cycles not in HALT) and instr_cnt[31:0]
//     (transitions into FETCH), both cleared by reset and wrapping.
//
//   Memory handshake: a memory state raises mem_read or mem_write and keeps
//   it, with every other output unchanged, until it samples mem_ready=1 on a
//   rising edge; that edge completes the access and leaves the state.
//   mem_ready is ignored in every non-memory state.
module mips_mc_controller
  import mips_mc_pkg::*;
#(
  parameter int ALU_CTRL_W    = 3,
  parameter int STATE_W       = 5,
  parameter int STRICT_DECODE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  i_or_d,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic [1:0]            reg_dst,
  output logic [1:0]            mem_to_reg,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            pc_src,
  output logic [STATE_W-1:0]    state_o,
  output logic                  illegal_op
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]           cycle_cnt,
  output logic [31:0]           instr_cnt
`endif
);

  state_t                  r_state;
  state_t                  w_next_state;
  state_t                  w_illegal_next;
  logic [ALU_CTRL_W-1:0]   w_funct_alu;
  logic                    w_funct_invalid;

  assign w_illegal_next = (STRICT_DECODE != 0) ? S_HALT : S_FETCH;

  mips_mc_alu_decoder #(
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_decoder (
    .i_funct       (funct),
    .o_alu_control (w_funct_alu),
    .o_invalid     (w_funct_invalid)
  );

  // State register. Reset lands in FETCH immediately, so a write-back state
  // interrupted by reset never gets to assert its enables on the next edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and outputs.
  always_comb begin
    w_next_state = r_state;
    pc_en        = 1'b0;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_dst      = REG_DST_RT;
    mem_to_reg   = M2R_ALUOUT;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_B;
    alu_control  = ALU_CTRL_W'(ALU_AND);
    pc_src       = PCSRC_ALU;
    illegal_op   = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = SRCB_FOUR;
        alu_control = ALU_CTRL_W'(ALU_ADD);
        // PC and IR load only when the fetch completes; held off during
        // reset so nothing loads while the core is being reset.
        ir_write    = mem_ready & reset;
        pc_en       = mem_ready & reset;
        if (mem_ready) w_next_state = S_DECODE;
      end

      S_DECODE: begin
        alu_src_b   = SRCB_IMM_SH;
        alu_control = ALU_CTRL_W'(ALU_ADD);
        case (op)
          OP_RTYPE:      w_next_state = (funct == FN_JR) ? S_JR : S_EXEC_R;
          OP_LW, OP_SW:  w_next_state = S_MEM_ADR;
          OP_BEQ, OP_BNE: w_next_state = S_BRANCH;
          OP_ADDI:       w_next_state = S_ADDI_EX;
          OP_J:          w_next_state = S_JUMP;
          OP_JAL:        w_next_state = S_JAL;
          default:       w_next_state = w_illegal_next;
        endcase
      end

      S_MEM_ADR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        alu_control  = ALU_CTRL_W'(ALU_ADD);
        w_next_state = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) w_next_state = S_MEM_WB;
      end

      S_MEM_WB: begin
        reg_dst      = REG_DST_RT;
        mem_to_reg   = M2R_DATA;
        reg_write    = 1'b1;
        w_next_state = S_FETCH;
      end

      S_MEM_WR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) w_next_state = S_FETCH;
      end

      S_EXEC_R: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_B;
        alu_control  = w_funct_alu;
        w_next_state = w_funct_invalid ? w_illegal_next : S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_dst      = REG_DST_RD;
        mem_to_reg   = M2R_ALUOUT;
        reg_write    = 1'b1;
        w_next_state = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_B;
        alu_control  = ALU_CTRL_W'(ALU_SUB);
        pc_src       = PCSRC_ALUOUT;
        // bne takes the branch on a non-zero difference, beq on zero.
        if (is_branch_op(op)) pc_en = (op == OP_BNE) ? ~zero : zero;
        w_next_state = S_FETCH;
      end

      S_ADDI_EX: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        alu_control  = ALU_CTRL_W'(ALU_ADD);
        w_next_state = S_ADDI_WB;
      end

      S_ADDI_WB: begin
        reg_dst      = REG_DST_RT;
        mem_to_reg   = M2R_ALUOUT;
        reg_write    = 1'b1;
        w_next_state = S_FETCH;
      end

      S_JUMP: begin
        pc_src       = PCSRC_JUMP;
        pc_en        = 1'b1;
        w_next_state = S_FETCH;
      end

      S_JAL: begin
        // PC already holds PC+4 from FETCH, so $31 is written with it while
        // the PC takes the jump target on the same edge.
        pc_src       = PCSRC_JUMP;
        pc_en        = 1'b1;
        reg_dst      = REG_DST_RA;
        mem_to_reg   = M2R_PC;
        reg_write    = 1'b1;
        w_next_state = S_FETCH;
      end

      S_JR: begin
        pc_src       = PCSRC_REG;
        pc_en        = 1'b1;
        w_next_state = S_FETCH;
      end

      S_HALT: begin
        illegal_op   = 1'b1;
        w_next_state = S_HALT;
      end

      default: begin
        w_next_state = w_illegal_next;
      end
    endcase
  end

  assign state_o = STATE_W'(r_state);

`ifdef MC_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_cnt <= 32'd0;
      r_instr_cnt <= 32'd0;
    end else begin
      if (r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if ((w_next_state == S_FETCH) && (r_state != S_FETCH))
        r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller
//   Directed bench for mips_mc_controller (default parameters). Each driven
//   cycle pushes the hand-computed output vector for that cycle; a monitor
//   compares it against the DUT on the falling edge.
module tb_mips_mc_controller;

  localparam int VW = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic [1:0]  reg_dst, mem_to_reg;
  logic        reg_write, alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_control;
  logic [1:0]  pc_src;
  logic [4:0]  state_o;
  logic        illegal_op;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  always #5 clk = ~clk;

  mips_mc_controller dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_en       (pc_en),
    .i_or_d      (i_or_d),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .pc_src      (pc_src),
    .state_o     (state_o),
    .illegal_op  (illegal_op)
`ifdef MC_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instr_cnt   (instr_cnt)
`endif
  );

  // ---------------- expected vectors ----------------
  // {state, pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
  //  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control, pc_src,
  //  illegal_op}
  function automatic logic [VW-1:0] ev(
    input logic [4:0] st, input logic pe, iod, mrd, mwr, irw,
    input logic [1:0] rd, m2r, input logic rw, sa, input logic [1:0] sb,
    input logic [2:0] alu, input logic [1:0] ps, input logic ill);
    return {st, pe, iod, mrd, mwr, irw, rd, m2r, rw, sa, sb, alu, ps, ill};
  endfunction

  function automatic logic [VW-1:0] v_fetch(input logic mr);
    return ev(5'd0, mr, 0, 1, 0, mr, 2'd0, 2'd0, 0, 0, 2'd1, 3'd2, 2'd0, 0);
  endfunction
  function automatic logic [VW-1:0] v_exec(input logic [2:0] alu);
    return ev(5'd6, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd0, alu, 2'd0, 0);
  endfunction
  function automatic logic [VW-1:0] v_branch(input logic pe);
    return ev(5'd8, pe, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd0, 3'd6, 2'd1, 0);
  endfunction

  localparam logic [VW-1:0] V_DECODE = ev(5'd1, 0,0,0,0,0, 2'd0,2'd0, 0,0, 2'd3, 3'd2, 2'd0, 0);
  localparam logic [VW-1:0] V_MEMADR = ev(5'd2, 0,0,0,0,0, 2'd0,2'd0, 0,1, 2'd2, 3'd2, 2'd0, 0);
  localparam logic [VW-1:0] V_MEMRD  = ev(5'd3, 0,1,1,0,0, 2'd0,2'd0, 0,0, 2'd0, 3'd0, 2'd0, 0);
  localparam logic [VW-1:0] V_MEMWB  = ev(5'd4, 0,0,0,0,0, 2'd0,2'd1, 1,0, 2'd0, 3'd0, 2'd0, 0);
  localparam logic [VW-1:0] V_MEMWR  = ev(5'd5, 0,1,0,1,0, 2'd0,2'd0, 0,0, 2'd0, 3'd0, 2'd0, 0);
  localparam logic [VW-1:0] V_ALUWB  = ev(5'd7, 0,0,0,0,0, 2'd1,2'd0, 1,0, 2'd0, 3'd0, 2'd0, 0);
  localparam logic [VW-1:0] V_ADDIEX = ev(5'd9, 0,0,0,0,0, 2'd0,2'd0, 0,1, 2'd2, 3'd2, 2'd0, 0);
  localparam logic [VW-1:0] V_ADDIWB = ev(5'd10,0,0,0,0,0, 2'd0,2'd0, 1,0, 2'd0, 3'd0, 2'd0, 0);
  localparam logic [VW-1:0] V_JUMP   = ev(5'd11,1,0,0,0,0, 2'd0,2'd0, 0,0, 2'd0, 3'd0, 2'd2, 0);
  localparam logic [VW-1:0] V_JAL    = ev(5'd12,1,0,0,0,0, 2'd2,2'd2, 1,0, 2'd0, 3'd0, 2'd2, 0);
  localparam logic [VW-1:0] V_JR     = ev(5'd13,1,0,0,0,0, 2'd0,2'd0, 0,0, 2'd0, 3'd0, 2'd3, 0);
  localparam logic [VW-1:0] V_HALT   = ev(5'd14,0,0,0,0,0, 2'd0,2'd0, 0,0, 2'd0, 3'd0, 2'd0, 1);

  logic [VW-1:0] w_act;
  assign w_act = {state_o, pc_en, i_or_d, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                  alu_control, pc_src, illegal_op};

  // ---------------- scoreboard ----------------
  logic [VW-1:0] exp_q[$];
  string         tag_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  string         cur_tag  = "init";

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endfunction

  initial begin : monitor
    logic [VW-1:0] e;
    string         t;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, 32'(w_act), 32'(e));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic r, input logic [5:0] o, f,
                     input logic z, m, input logic [VW-1:0] e);
    reset = r; op = o; funct = f; zero = z; mem_ready = m;
    exp_q.push_back(e);
    tag_q.push_back(cur_tag);
    @(posedge clk);
    #1;
  endtask

  // R-type stimulus table: funct and the ALU code it must select.
  logic [5:0] rt_fn  [4] = '{6'h22, 6'h24, 6'h25, 6'h2A};
  logic [2:0] rt_alu [4] = '{3'd6,  3'd0,  3'd1,  3'd7};
  // Branch table: op, zero, expected pc_en.
  logic [5:0] br_op  [4] = '{6'h05, 6'h05, 6'h04, 6'h04};
  logic       br_z   [4] = '{1'b0,  1'b1,  1'b0,  1'b1};
  logic       br_pe  [4] = '{1'b1,  1'b0,  1'b0,  1'b1};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b0; op = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state; mem_ready high must not leak into pc_en/ir_write.
    cur_tag = "reset";
    cyc(0, 6'h00, 6'h00, 0, 0, v_fetch(0));
    cyc(0, 6'h00, 6'h00, 0, 1, v_fetch(0));

    // add: FETCH, DECODE, EXEC_R, ALU_WB
    cur_tag = "add";
    cyc(1, 6'h00, 6'h20, 0, 1, v_fetch(1));
    cyc(1, 6'h00, 6'h20, 0, 1, V_DECODE);
    cyc(1, 6'h00, 6'h20, 0, 1, v_exec(3'd2));
    cyc(1, 6'h00, 6'h20, 0, 1, V_ALUWB);

    // remaining R-type functs
    cur_tag = "rtype";
    for (int i = 0; i < 4; i++) begin
      cyc(1, 6'h00, rt_fn[i], 0, 1, v_fetch(1));
      cyc(1, 6'h00, rt_fn[i], 0, 1, V_DECODE);
      cyc(1, 6'h00, rt_fn[i], 0, 1, v_exec(rt_alu[i]));
      cyc(1, 6'h00, rt_fn[i], 0, 1, V_ALUWB);
    end

    // lw with three wait cycles in MEM_RD: 8 cycles total
    cur_tag = "lw_stall";
    cyc(1, 6'h23, 6'h00, 0, 1, v_fetch(1));
    cyc(1, 6'h23, 6'h00, 0, 1, V_DECODE);
    cyc(1, 6'h23, 6'h00, 0, 1, V_MEMADR);
    cyc(1, 6'h23, 6'h00, 0, 0, V_MEMRD);
    cyc(1, 6'h23, 6'h00, 0, 0, V_MEMRD);
    cyc(1, 6'h23, 6'h00, 0, 0, V_MEMRD);
    cyc(1, 6'h23, 6'h00, 0, 1, V_MEMRD);
    cyc(1, 6'h23, 6'h00, 0, 1, V_MEMWB);

    // sw with a fetch stall, mem_ready low in DECODE/MEM_ADR (ignored)
    cur_tag = "sw_stall";
    cyc(1, 6'h2B, 6'h00, 0, 0, v_fetch(0));
    cyc(1, 6'h2B, 6'h00, 0, 1, v_fetch(1));
    cyc(1, 6'h2B, 6'h00, 0, 0, V_DECODE);
    cyc(1, 6'h2B, 6'h00, 0, 0, V_MEMADR);
    cyc(1, 6'h2B, 6'h00, 0, 0, V_MEMWR);
    cyc(1, 6'h2B, 6'h00, 0, 1, V_MEMWR);

    // bne/beq with both zero values
    cur_tag = "branch";
    for (int i = 0; i < 4; i++) begin
      cyc(1, br_op[i], 6'h00, br_z[i], 1, v_fetch(1));
      cyc(1, br_op[i], 6'h00, br_z[i], 1, V_DECODE);
      cyc(1, br_op[i], 6'h00, br_z[i], 1, v_branch(br_pe[i]));
    end

    cur_tag = "addi";
    cyc(1, 6'h08, 6'h00, 0, 1, v_fetch(1));
    cyc(1, 6'h08, 6'h00, 0, 1, V_DECODE);
    cyc(1, 6'h08, 6'h00, 0, 1, V_ADDIEX);
    cyc(1, 6'h08, 6'h00, 0, 1, V_ADDIWB);

    cur_tag = "j";
    cyc(1, 6'h02, 6'h00, 0, 1, v_fetch(1));
    cyc(1, 6'h02, 6'h00, 0, 1, V_DECODE);
    cyc(1, 6'h02, 6'h00, 0, 1, V_JUMP);

    cur_tag = "jal";
    cyc(1, 6'h03, 6'h00, 0, 1, v_fetch(1));
    cyc(1, 6'h03, 6'h00, 0, 1, V_DECODE);
    cyc(1, 6'h03, 6'h00, 0, 1, V_JAL);

    cur_tag = "jr";
    cyc(1, 6'h00, 6'h08, 0, 1, v_fetch(1));
    cyc(1, 6'h00, 6'h08, 0, 1, V_DECODE);
    cyc(1, 6'h00, 6'h08, 0, 1, V_JR);

    // reset pulsed low in the middle of a stalled MEM_WR
    cur_tag = "sw_reset";
    cyc(1, 6'h2B, 6'h00, 0, 1, v_fetch(1));
    cyc(1, 6'h2B, 6'h00, 0, 1, V_DECODE);
    cyc(1, 6'h2B, 6'h00, 0, 1, V_MEMADR);
    mem_ready = 1'b0;
    exp_q.push_back(V_MEMWR);
    tag_q.push_back(cur_tag);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_mem_write", 32'(mem_write), 32'd0);
    chk("async_state", 32'(state_o), 32'd0);
`ifdef MC_PERF_CNT_EN
    chk("cycle_cnt_reset", cycle_cnt, 32'd0);
    chk("instr_cnt_reset", instr_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    cyc(0, 6'h2B, 6'h00, 0, 1, v_fetch(0));

    // j after reset release; counters see 3 cycles and 1 instruction
    cur_tag = "j_after_reset";
    cyc(1, 6'h02, 6'h00, 0, 1, v_fetch(1));
    cyc(1, 6'h02, 6'h00, 0, 1, V_DECODE);
    cyc(1, 6'h02, 6'h00, 0, 1, V_JUMP);
`ifdef MC_PERF_CNT_EN
    chk("cycle_cnt_j", cycle_cnt, 32'd3);
    chk("instr_cnt_j", instr_cnt, 32'd1);
`endif

    // unknown R-type funct: EXEC_R then HALT
    cur_tag = "bad_funct";
    cyc(1, 6'h00, 6'h3F, 0, 1, v_fetch(1));
    cyc(1, 6'h00, 6'h3F, 0, 1, V_DECODE);
    cyc(1, 6'h00, 6'h3F, 0, 1, v_exec(3'd2));
    cyc(1, 6'h00, 6'h3F, 0, 1, V_HALT);
    cyc(0, 6'h00, 6'h00, 0, 0, v_fetch(0));

    // illegal opcode: HALT held for 10 cycles whatever mem_ready does
    cur_tag = "illegal_op";
    cyc(1, 6'h3F, 6'h00, 0, 1, v_fetch(1));
    cyc(1, 6'h3F, 6'h00, 0, 1, V_DECODE);
    for (int i = 0; i < 10; i++) cyc(1, 6'h3F, 6'h00, 0, 1'(i), V_HALT);
    cur_tag = "halt_reset";
    cyc(0, 6'h00, 6'h20, 0, 0, v_fetch(0));
    cyc(1, 6'h00, 6'h20, 0, 1, v_fetch(1));
    cyc(1, 6'h00, 6'h20, 0, 1, V_DECODE);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
